ppf_commutator: RTL and testbench

Input commutator for the direct polyphase filter bank.
- Accepts a serial complex sample stream and deals consecutive samples across BRANCH_NUM branch slots.
- When a full frame is collected, presents all slots in parallel, one register per `filtering` branch instance.
- Sits directly upstream of the branch filters. Its frame strobe is the decimated-rate valid for the whole branch array.

---
 rtl/ppf_commutator_pkg.sv | 31 +++
 rtl/ppf_commutator_if.sv | 33 +++
 rtl/ppf_comm_ctrl.sv | 73 +++++++
 rtl/ppf_commutator.sv | 96 +++++++++
 tb/tb_ppf_commutator.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ppf_commutator_pkg.sv
// Shared definitions for the polyphase filter bank input commutator.
// Provides the counter-width helper, the FSM state encoding and the
// packed-bus slice helper used by ppf_commutator and ppf_comm_ctrl.
package ppf_pkg;

   // Number of bits needed to hold the value v (at least one bit).
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

   // Commutator FSM states: IDLE holds no partial frame, FILL holds one.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_e;

   // Lowest bit of branch b inside a packed per-branch bus.
   function automatic int slice_lsb(input int b, input int width);
      return b * width;
   endfunction

endpackage

// File: rtl/ppf_commutator_if.sv
// Sample-stream / branch-bus bundle for ppf_commutator.
// Transfer rule: there is no backpressure. Every cycle with data_valid_i
// high transfers exactly one sample (data_real_i, data_imag_i, sync_i);
// data_valid_o is a one-cycle strobe marking a new frame on the branch bus.
interface ppf_commutator_if #(
   parameter int DIN_WIDTH  = 16,
   parameter int BRANCH_NUM = 8
);
   import ppf_pkg::*;

   logic                             data_valid_i;
   logic                             sync_i;
   logic signed [DIN_WIDTH-1:0]      data_real_i;
   logic signed [DIN_WIDTH-1:0]      data_imag_i;
   logic [BRANCH_NUM*DIN_WIDTH-1:0]  data_real_o;
   logic [BRANCH_NUM*DIN_WIDTH-1:0]  data_imag_o;
   logic                             data_valid_o;
   logic                             frame_err_o;
   state_e                           dbg_state_o;

   // Sample source and branch-array consumer side.
   modport master (
      output data_valid_i, sync_i, data_real_i, data_imag_i,
      input  data_real_o, data_imag_o, data_valid_o, frame_err_o, dbg_state_o
   );

   // Commutator side.
   modport slave (
      input  data_valid_i, sync_i, data_real_i, data_imag_i,
      output data_real_o, data_imag_o, data_valid_o, frame_err_o, dbg_state_o
   );

endinterface

// File: rtl/ppf_comm_ctrl.sv
// Slot counter, IDLE/FILL FSM and sync realignment for the commutator.
// Tells the datapath which slot the current sample belongs to, when the
// frame completes (same edge) and raises a registered error pulse when a
// partial frame is thrown away by sync_i.
module ppf_comm_ctrl
   import ppf_pkg::*;
#(
   parameter int BRANCH_NUM = 8,
   parameter int SW         = clogb2(BRANCH_NUM-1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          valid_i,
   input  logic          sync_i,
   output logic          wr_en_o,
   output logic [SW-1:0] wr_slot_o,
   output logic          frame_done_o,
   output logic          frame_err_o,
   output state_e        state_o
);

   state_e        state_q;
   logic [SW-1:0] slot_q;
   logic          err_q;
   logic          last_slot;
   logic          restart;

   // Slot decode: a sync inside a partial frame restarts at slot 0.
   always_comb begin
      last_slot    = (slot_q == SW'(BRANCH_NUM-1));
      restart      = valid_i && sync_i && (state_q == ST_FILL);
      wr_en_o      = valid_i;
      wr_slot_o    = restart ? '0 : slot_q;
      frame_done_o = valid_i && !restart && last_slot;
   end

   // FSM, slot counter and registered error pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         slot_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= restart;
         if (valid_i) begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_FILL;
                  slot_q  <= SW'(1);
               end
               ST_FILL: begin
                  if (restart) begin
                     slot_q <= SW'(1);
                  end else if (last_slot) begin
                     state_q <= ST_IDLE;
                     slot_q  <= '0;
                  end else begin
                     slot_q <= slot_q + SW'(1);
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  slot_q  <= '0;
               end
            endcase
         end
      end
   end

   assign frame_err_o = err_q;
   assign state_o     = state_q;

endmodule

// File: rtl/ppf_commutator.sv
// Input commutator for the direct polyphase filter bank.
// Deals a serial complex stream across BRANCH_NUM slots and presents a
// complete frame in parallel, one register per branch filter.
// Optional macro PPF_COMMUTATOR_REVERSE_EN: slot k feeds branch
// BRANCH_NUM-1-k (standard PPF order); otherwise slot k feeds branch k.
module ppf_commutator
   import ppf_pkg::*;
#(
   parameter int DIN_WIDTH  = 16,
   parameter int BRANCH_NUM = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   ppf_commutator_if.slave bus
);

   localparam int SW = clogb2(BRANCH_NUM-1);

   logic signed [DIN_WIDTH-1:0] shadow_re_q [BRANCH_NUM];
   logic signed [DIN_WIDTH-1:0] shadow_im_q [BRANCH_NUM];
   logic signed [DIN_WIDTH-1:0] out_re_q    [BRANCH_NUM];
   logic signed [DIN_WIDTH-1:0] out_im_q    [BRANCH_NUM];
   logic                        valid_q;

   logic          wr_en;
   logic [SW-1:0] wr_slot;
   logic [SW-1:0] dst;
   logic          frame_done;
   logic          frame_err;
   state_e        state;

   // Slot to branch routing.
   function automatic logic [SW-1:0] map_slot(input logic [SW-1:0] k);
`ifdef PPF_COMMUTATOR_REVERSE_EN
      return SW'(BRANCH_NUM-1) - k;
`else
      return k;
`endif
   endfunction

   ppf_comm_ctrl #(
      .BRANCH_NUM (BRANCH_NUM),
      .SW         (SW)
   ) u_ctrl (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .valid_i      (bus.data_valid_i),
      .sync_i       (bus.sync_i),
      .wr_en_o      (wr_en),
      .wr_slot_o    (wr_slot),
      .frame_done_o (frame_done),
      .frame_err_o  (frame_err),
      .state_o      (state)
   );

   assign dst = map_slot(wr_slot);

   // Shadow capture and frame transfer; the closing sample bypasses the
   // shadow so the whole frame appears on the edge that accepts it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int b = 0; b < BRANCH_NUM; b++) begin
            shadow_re_q[b] <= '0;
            shadow_im_q[b] <= '0;
            out_re_q[b]    <= '0;
            out_im_q[b]    <= '0;
         end
         valid_q <= 1'b0;
      end else begin
         valid_q <= frame_done;
         if (wr_en) begin
            shadow_re_q[dst] <= bus.data_real_i;
            shadow_im_q[dst] <= bus.data_imag_i;
         end
         if (frame_done) begin
            for (int b = 0; b < BRANCH_NUM; b++) begin
               out_re_q[b] <= shadow_re_q[b];
               out_im_q[b] <= shadow_im_q[b];
            end
            out_re_q[dst] <= bus.data_real_i;
            out_im_q[dst] <= bus.data_imag_i;
         end
      end
   end

   // Pack per-branch output registers onto the parallel bus.
   for (genvar b = 0; b < BRANCH_NUM; b++) begin : g_pack
      assign bus.data_real_o[slice_lsb(b, DIN_WIDTH) +: DIN_WIDTH] = out_re_q[b];
      assign bus.data_imag_o[slice_lsb(b, DIN_WIDTH) +: DIN_WIDTH] = out_im_q[b];
   end

   assign bus.data_valid_o = valid_q;
   assign bus.frame_err_o  = frame_err;
   assign bus.dbg_state_o  = state;

endmodule

// File: tb/tb_ppf_commutator.sv
// Bench for ppf_commutator with BRANCH_NUM=4, DIN_WIDTH=16. Works with or
// without PPF_COMMUTATOR_REVERSE_EN; the frame model and literal frames
// follow the same macro.
module tb_ppf_commutator;
   import ppf_pkg::*;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int BW = W * N;

`ifdef PPF_COMMUTATOR_REVERSE_EN
   localparam logic [BW-1:0] L1_RE = 64'h0001_0002_0003_0004;
   localparam logic [BW-1:0] L1_IM = 64'hFFFF_FFFE_FFFD_FFFC;
   localparam logic [BW-1:0] L2_RE = 64'h000A_000B_000C_000D;
   localparam logic [BW-1:0] L3_RE = 64'h001E_001F_0020_0021;
   localparam logic [BW-1:0] L4_RE = 64'h0028_0029_002A_002B;
   localparam logic [BW-1:0] L5_RE = 64'h0044_0045_0046_0047;
`else
   localparam logic [BW-1:0] L1_RE = 64'h0004_0003_0002_0001;
   localparam logic [BW-1:0] L1_IM = 64'hFFFC_FFFD_FFFE_FFFF;
   localparam logic [BW-1:0] L2_RE = 64'h000D_000C_000B_000A;
   localparam logic [BW-1:0] L3_RE = 64'h0021_0020_001F_001E;
   localparam logic [BW-1:0] L4_RE = 64'h002B_002A_0029_0028;
   localparam logic [BW-1:0] L5_RE = 64'h0047_0046_0045_0044;
`endif

   // Clock and reset.
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ppf_commutator_if #(.DIN_WIDTH(W), .BRANCH_NUM(N)) bus_if ();

   ppf_commutator #(
      .DIN_WIDTH  (W),
      .BRANCH_NUM (N)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_if)
   );

   int   checks     = 0;
   int   errors     = 0;
   int   strobe_cnt = 0;
   logic chk_en     = 1'b0;

   // Model state: samples of the frame being collected, oldest first.
   logic [2*W-1:0] exp_q[$];
   logic [BW-1:0]  exp_re = '0;
   logic [BW-1:0]  exp_im = '0;
   logic           exp_v  = 1'b0;
   logic           exp_e  = 1'b0;

   function automatic int branch_of(input int k);
`ifdef PPF_COMMUTATOR_REVERSE_EN
      return N - 1 - k;
`else
      return k;
`endif
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: collect samples, drop them on an in-frame sync, publish
   // a full frame to its branches.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_re = '0;
         exp_im = '0;
         exp_v  = 1'b0;
         exp_e  = 1'b0;
      end else begin
         exp_v = 1'b0;
         exp_e = 1'b0;
         if (bus_if.data_valid_i) begin
            if (bus_if.sync_i && exp_q.size() > 0) begin
               exp_q.delete();
               exp_e = 1'b1;
            end
            exp_q.push_back({bus_if.data_real_i, bus_if.data_imag_i});
            if (exp_q.size() == N) begin
               for (int k = 0; k < N; k++) begin
                  exp_re[branch_of(k)*W +: W] = exp_q[k][2*W-1:W];
                  exp_im[branch_of(k)*W +: W] = exp_q[k][W-1:0];
               end
               exp_v = 1'b1;
               exp_q.delete();
            end
         end
      end
   end

   // Scoreboard compare, every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("data_valid_o", BW'(bus_if.data_valid_o), BW'(exp_v));
         check("frame_err_o",  BW'(bus_if.frame_err_o),  BW'(exp_e));
         check("data_real_o",  bus_if.data_real_o, exp_re);
         check("data_imag_o",  bus_if.data_imag_o, exp_im);
         if (bus_if.data_valid_o) strobe_cnt++;
      end
   end

   // Driver: present one cycle of inputs, return just after the edge.
   task automatic step(input logic r, input logic v, input logic s, input int re);
      rst                 = r;
      bus_if.data_valid_i = v;
      bus_if.sync_i       = s;
      bus_if.data_real_i  = W'(re);
      bus_if.data_imag_i  = W'(-re);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus_if.data_valid_i = 1'b0;
      bus_if.sync_i       = 1'b0;
      bus_if.data_real_i  = '0;
      bus_if.data_imag_i  = '0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk_en = 1'b1;
      check("reset real", bus_if.data_real_o, '0);
      check("reset valid", BW'(bus_if.data_valid_o), '0);
      check("reset state", BW'(bus_if.dbg_state_o), BW'(ST_IDLE));

      // Continuous frame 1..4.
      step(0, 1, 0, 1);
      step(0, 1, 0, 2);
      check("state fill", BW'(bus_if.dbg_state_o), BW'(ST_FILL));
      step(0, 1, 0, 3);
      check("no early strobe", BW'(bus_if.data_valid_o), '0);
      step(0, 1, 0, 4);
      check("frame1 real", bus_if.data_real_o, L1_RE);
      check("frame1 imag", bus_if.data_imag_o, L1_IM);
      check("frame1 strobe", BW'(bus_if.data_valid_o), BW'(1));
      step(0, 0, 0, 0);
      check("frame1 strobe end", BW'(bus_if.data_valid_o), '0);
      check("frame1 hold", bus_if.data_real_o, L1_RE);

      // Gap in the middle of a frame.
      step(0, 1, 0, 10);
      step(0, 1, 0, 11);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 77);
      step(0, 1, 0, 12);
      step(0, 1, 0, 13);
      check("gap frame real", bus_if.data_real_o, L2_RE);

      // Sync realignment inside a partial frame.
      step(0, 1, 0, 20);
      step(0, 1, 0, 21);
      step(0, 1, 1, 30);
      check("sync err pulse", BW'(bus_if.frame_err_o), BW'(1));
      step(0, 1, 0, 31);
      check("sync err end", BW'(bus_if.frame_err_o), '0);
      step(0, 1, 0, 32);
      step(0, 1, 0, 33);
      check("sync frame real", bus_if.data_real_o, L3_RE);

      // Reset mid-frame, asserted together with a valid sync sample.
      step(0, 1, 0, 50);
      step(0, 1, 0, 51);
      step(1, 1, 1, 99);
      check("mid reset real", bus_if.data_real_o, '0);
      check("mid reset err", BW'(bus_if.frame_err_o), '0);
      step(0, 1, 0, 40);
      step(0, 1, 0, 41);
      step(0, 1, 0, 42);
      check("post reset real", bus_if.data_real_o, '0);
      step(0, 1, 0, 43);
      check("post reset frame", bus_if.data_real_o, L4_RE);

      // Sync arriving in the last slot of a frame.
      step(0, 1, 0, 80);
      step(0, 1, 0, 81);
      step(0, 1, 0, 82);
      step(0, 1, 1, 90);
      step(0, 1, 0, 91);
      step(0, 1, 0, 92);
      step(0, 1, 0, 93);

      // Twelve continuous samples, the first carrying a sync in IDLE.
      step(0, 0, 0, 0);
      strobe_cnt = 0;
      for (int i = 0; i < 12; i++) step(0, 1, (i == 0), 60 + i);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("stream strobes", BW'(strobe_cnt), BW'(3));
      check("stream last frame", bus_if.data_real_o, L5_RE);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
